// File: rtl/parity_lane_gen_check.sv
// Streaming per-lane parity generator/checker.
// Splits each accepted beat into DATA_W/LANE_W lanes, computes one parity bit per
// lane (even or odd), optionally compares it with received parity, and presents
// the result through a one-deep registered output stage with valid/ready flow
// control. Error telemetry: a sticky flag and a saturating count of erroring beats.
module parity_lane_gen_check #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8,
    parameter int CNT_W  = 16,
    localparam int NLANES = DATA_W / LANE_W
) (
    input  logic              clk,
    input  logic              reset,
    // upstream beat
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [NLANES-1:0] parity_in,
    input  logic              odd_mode,
    input  logic              check_en,
    // downstream beat
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [NLANES-1:0] parity_out,
    output logic [NLANES-1:0] lane_err,
    // error status
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count,
    input  logic              err_clear
);

    // A partial lane would silently get no parity bit, so refuse to elaborate.
    if ((DATA_W % LANE_W) != 0) begin : g_bad_lane_width
        $error("parity_lane_gen_check: DATA_W (%0d) must be a multiple of LANE_W (%0d)",
               DATA_W, LANE_W);
    end

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    stage_state_t      state;
    logic              accept;
    logic [NLANES-1:0] parity_calc;
    logic [NLANES-1:0] err_calc;
    logic              beat_err;

    // The stage can take a new beat when empty or when its current beat leaves now.
    assign out_valid = (state == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    // Per-lane parity of the incoming beat; lane 0 sits in the LSBs.
    always_comb begin
        // NOTE: give every combinational output a default first so no path leaves it unassigned and no latch is inferred.
        parity_calc = '0;
        for (int k = 0; k < NLANES; k++) begin
            parity_calc[k] = (^data_in[k*LANE_W +: LANE_W]) ^ odd_mode;
        end
    end

    // Lane mismatches only mean something in check mode.
    assign err_calc = check_en ? (parity_calc ^ parity_in) : '0;
    assign beat_err = accept && (|err_calc);

    // Output stage: load on accept, drain on out_ready, hold everything while stalled.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // NOTE: the data registers are reset too, because their value is visible on the ports right after reset.
            state      <= ST_EMPTY;
            data_out   <= '0;
            parity_out <= '0;
            lane_err   <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready && !accept) begin
                        state <= ST_EMPTY;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
            if (accept) begin
                data_out   <= data_in;
                parity_out <= parity_calc;
                lane_err   <= err_calc;
            end
        end
    end

    // Error status updates on the loading edge; a clear never swallows a coincident error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (err_clear) begin
            err_sticky <= beat_err;
            err_count  <= beat_err ? CNT_ONE : '0;
        end else if (beat_err) begin
            err_sticky <= 1'b1;
            if (err_count != CNT_MAX) begin
                err_count <= err_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_parity_lane_gen_check.sv
// Testbench for parity_lane_gen_check (32-bit data, 8-bit lanes, 4-bit error counter).
// Accepted beats are turned into expected outputs by a lane-counting reference
// model and queued; an independent monitor pops and compares each beat the DUT
// hands downstream. Error status is tracked by the model on every cycle.
module tb_parity_lane_gen_check;

    localparam int DATA_W  = 32;
    localparam int LANE_W  = 8;
    localparam int NL      = DATA_W / LANE_W;
    localparam int CNT_W   = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic [NL-1:0]     parity_in;
    logic              odd_mode;
    logic              check_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic [NL-1:0]     parity_out;
    logic [NL-1:0]     lane_err;
    logic              err_sticky;
    logic [CNT_W-1:0]  err_count;
    logic              err_clear;

    parity_lane_gen_check #(
        .DATA_W(DATA_W),
        .LANE_W(LANE_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .parity_in (parity_in),
        .odd_mode  (odd_mode),
        .check_en  (check_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .parity_out(parity_out),
        .lane_err  (lane_err),
        .err_sticky(err_sticky),
        .err_count (err_count),
        .err_clear (err_clear)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [NL-1:0]     p;
        logic [NL-1:0]     e;
    } beat_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t sb_q[$];
    int    m_cnt = 0;
    logic  m_sticky = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference parity: count the ones in each lane; an odd count means even parity bit 1.
    function automatic logic [NL-1:0] ref_par(input logic [DATA_W-1:0] d, input logic odd);
        logic [NL-1:0]     p;
        logic [LANE_W-1:0] lane;
        p = '0;
        for (int k = 0; k < NL; k++) begin
            lane = d[k*LANE_W +: LANE_W];
            p[k] = ((($countones(lane) % 2) == 1) != odd);
        end
        return p;
    endfunction

    // Input side: predict each accepted beat and the error status after the edge.
    always @(negedge clk) begin
        beat_t b;
        #4;
        if (!reset) begin
            check("err_count", 64'(err_count), 64'(m_cnt));
            check("err_sticky", 64'(err_sticky), 64'(m_sticky));
            if (in_valid && in_ready) begin
                b.d = data_in;
                b.p = ref_par(data_in, odd_mode);
                b.e = check_en ? (b.p ^ parity_in) : '0;
                sb_q.push_back(b);
                if (err_clear) begin
                    m_cnt    = (b.e != 0) ? 1 : 0;
                    m_sticky = (b.e != 0);
                end else if (b.e != 0) begin
                    m_sticky = 1'b1;
                    if (m_cnt < CNT_SAT) m_cnt = m_cnt + 1;
                end
            end else if (err_clear) begin
                m_cnt    = 0;
                m_sticky = 1'b0;
            end
        end
    end

    // Output side: every beat handed downstream must be the oldest predicted one.
    always @(negedge clk) begin
        beat_t b;
        #4;
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got data 0x%0h, expected no beat (t=%0t)", data_out, $time);
            end else begin
                b = sb_q.pop_front();
                check("beat_data", 64'(data_out), 64'(b.d));
                check("beat_parity", 64'(parity_out), 64'(b.p));
                check("beat_lane_err", 64'(lane_err), 64'(b.e));
            end
        end
    end

    // Offer one beat from a negedge and hold it until taken; returns on a negedge.
    task automatic send(input logic [DATA_W-1:0] d, input logic [NL-1:0] pin,
                        input logic odd, input logic chk);
        bit acc;
        acc       = 1'b0;
        in_valid  = 1'b1;
        data_in   = d;
        parity_in = pin;
        odd_mode  = odd;
        check_en  = chk;
        for (int n = 0; n < 50 && !acc; n++) begin
            #4;
            acc = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready=0 for 50 clks, expected acceptance (t=%0t)", $time);
        end
    endtask

    task automatic send_err(input logic [DATA_W-1:0] d);
        logic [NL-1:0] mask;
        mask = NL'($urandom_range(1, (1 << NL) - 1));
        send(d, ref_par(d, 1'b0) ^ mask, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] d_a;
        logic [DATA_W-1:0] d_b;
        logic [DATA_W-1:0] d_r;

        reset     = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        parity_in = '0;
        odd_mode  = 1'b0;
        check_en  = 1'b0;
        out_ready = 1'b1;
        err_clear = 1'b0;

        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_parity_out", 64'(parity_out), 64'd0);
        check("rst_lane_err", 64'(lane_err), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Generate, even parity
        send(32'h0103_0700, 4'b0000, 1'b0, 1'b0);
        check("gen_even_valid", 64'(out_valid), 64'd1);
        check("gen_even_parity", 64'(parity_out), 64'b1010);
        check("gen_even_lane_err", 64'(lane_err), 64'd0);

        // Generate, odd parity
        send(32'h0103_0700, 4'b1111, 1'b1, 1'b0);
        check("gen_odd_parity", 64'(parity_out), 64'b0101);
        check("gen_odd_err_count", 64'(err_count), 64'd0);

        // Check mode, lane 0 mismatch
        send(32'hFFFF_FFFF, 4'b0001, 1'b0, 1'b1);
        check("chk_lane_err", 64'(lane_err), 64'b0001);
        check("chk_err_sticky", 64'(err_sticky), 64'd1);
        check("chk_err_count", 64'(err_count), 64'd1);

        // Downstream stall with a second beat waiting
        @(negedge clk);
        out_ready = 1'b0;
        d_a = $urandom;
        d_b = $urandom;
        send(d_a, 4'b0000, 1'b0, 1'b0);
        in_valid  = 1'b1;
        data_in   = d_b;
        parity_in = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_data_out", 64'(data_out), 64'(d_a));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("stall_second_valid", 64'(out_valid), 64'd1);
        check("stall_second_data", 64'(data_out), 64'(d_b));

        // Counter saturation, then clear coinciding with an erroring beat
        for (int i = 0; i < 20; i++) begin
            d_r = $urandom;
            send_err(d_r);
        end
        check("sat_err_count", 64'(err_count), 64'(CNT_SAT));
        err_clear = 1'b1;
        d_r = $urandom;
        send_err(d_r);
        err_clear = 1'b0;
        check("clr_err_beat_count", 64'(err_count), 64'd1);
        check("clr_err_beat_sticky", 64'(err_sticky), 64'd1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("clr_idle_count", 64'(err_count), 64'd0);
        check("clr_idle_sticky", 64'(err_sticky), 64'd0);

        // Asynchronous reset in the middle of a stall
        for (int i = 0; i < 5; i++) begin
            d_r = $urandom;
            send_err(d_r);
        end
        out_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        check("pre_rst_err_count", 64'(err_count), 64'd5);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_err_count", 64'(err_count), 64'd0);
        check("async_rst_err_sticky", 64'(err_sticky), 64'd0);
        check("async_rst_data_out", 64'(data_out), 64'd0);
        sb_q.delete();
        m_cnt    = 0;
        m_sticky = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;

        // Random traffic: backpressure, mode changes, parity errors, occasional clears
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            err_clear = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            data_in   = $urandom;
            odd_mode  = 1'($urandom_range(0, 1));
            check_en  = 1'($urandom_range(0, 1));
            parity_in = ref_par(data_in, odd_mode) ^
                        (($urandom_range(0, 1) != 0) ? NL'($urandom) : NL'(0));
        end

        // Drain
        @(negedge clk);
        in_valid  = 1'b0;
        err_clear = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 10 && sb_q.size() != 0; n++) begin
            @(negedge clk);
        end
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
